// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver, LSB first.
// Synchronises the asynchronous serial line and rejects start-bit glitches.
// Each bit is sampled at mid-bit. A good byte is delivered with a one-cycle
// valid strobe. A bad stop bit raises a framing-error strobe instead.
//
// Ports:
//   clk_in        system clock
//   rst_in        synchronous, active-high reset
//   rx_in         asynchronous UART line, idle high
//   rx_dv_out     one-cycle strobe: rx_data_out holds a new good byte
//   rx_data_out   last good byte received, held between strobes
//   frame_err_out one-cycle strobe: stop bit sampled low, byte dropped
//   busy_out      high while a frame is being received (state != IDLE)
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 142
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  output logic       rx_dv_out,
  output logic [7:0] rx_data_out,
  output logic       frame_err_out,
  output logic       busy_out
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             sync1_q, rx_s;
  logic             dv_d, fe_d;
  logic [7:0]       data_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s    <= sync1_q;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shreg_q       <= '0;
      rx_dv_out     <= 1'b0;
      rx_data_out   <= '0;
      frame_err_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      rx_dv_out     <= dv_d;
      rx_data_out   <= data_d;
      frame_err_out <= fe_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    data_d  = rx_data_out;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      // Re-check the line half a bit in; a high line means it was a glitch.
      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      // Leave at mid-stop-bit so an immediately following start edge is seen.
      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s) begin
            dv_d   = 1'b1;
            data_d = shreg_q;
          end else begin
            fe_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_out = (state_q != S_IDLE);

endmodule
